// File: rtl/serial_detect_sched_if.sv
// serial_detect_sched_if
//   Request/response bundle between the sample collectors, the shared
//   pair-detector scheduler and the statistics unit.
//   req_valid/req_data/req_ready : per-requester word handshake (one-hot ready)
//   rsp_valid/rsp_ready          : result handshake
//   rsp_id/rsp_count/rsp_mask    : owner, detect count and per-bit detect mask
//   busy                         : scheduler is shifting or holding a result
//   master = requesters/consumer side, slave = scheduler side.
interface serial_detect_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ),
    parameter int CW    = $clog2(WIDTH / 2 + 1)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [CW-1:0]         rsp_count;
    logic [WIDTH-1:0]      rsp_mask;
    logic                  busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_mask, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count, rsp_mask, busy
    );
endinterface

// File: rtl/serial_detect_sched.sv
// serial_detect_sched
//   Round-robin scheduler sharing one bit-serial "two equal consecutive bits"
//   detector among NREQ requesters. A granted word is shifted MSB-first; the
//   result (count, per-bit mask, owner id) is held until the consumer accepts.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of serial_detect_sched_if (request and response paths)
module serial_detect_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ),
    parameter int CW    = $clog2(WIDTH / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_detect_sched_if.slave bus
);
    localparam int          BW     = $clog2(WIDTH);
    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESP} state_t;
    typedef enum logic [1:0] {D_START, D_GOT1, D_GOT0} det_t;

    state_t           state_q;
    det_t             det_q;
    logic [WIDTH-1:0] word_q;
    logic [BW-1:0]    bit_idx_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mask_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [CW-1:0]    rsp_count_q;
    logic [WIDTH-1:0] rsp_mask_q;
    logic             busy_q;

    logic [NREQ-1:0]  grant_d;
    logic             grant_any_d;
    logic [IDW-1:0]   grant_id_d;
    logic [WIDTH-1:0] word_d;

    det_t             det_d;
    logic             hit_d;
    logic             cur_bit;
    logic [WIDTH-1:0] mask_d;
    logic [CW-1:0]    count_d;

    // Arbiter: first valid requester at or above rr_ptr, wrapping. Only
    // offered in IDLE and never while reset is asserted.
    always_comb begin
        int unsigned k;
        grant_d     = '0;
        grant_any_d = 1'b0;
        grant_id_d  = '0;
        word_d      = '0;
        k           = 0;
        if (state_q == S_IDLE && !reset) begin
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                k = (32'(rr_ptr_q) + i) % NREQ_U;
                if (!grant_any_d && bus.req_valid[k]) begin
                    grant_any_d = 1'b1;
                    grant_id_d  = IDW'(k);
                    word_d      = bus.req_data[k*WIDTH +: WIDTH];
                end
            end
            grant_d[grant_id_d] = grant_any_d;
        end
    end

    // Pair detector step for the current bit; a detect returns to START so
    // pairs never overlap.
    always_comb begin
        cur_bit = word_q[bit_idx_q];
        det_d   = det_q;
        hit_d   = 1'b0;
        case (det_q)
            D_START: det_d = cur_bit ? D_GOT1 : D_GOT0;
            D_GOT1: begin
                if (cur_bit) begin
                    hit_d = 1'b1;
                    det_d = D_START;
                end else begin
                    det_d = D_GOT0;
                end
            end
            D_GOT0: begin
                if (!cur_bit) begin
                    hit_d = 1'b1;
                    det_d = D_START;
                end else begin
                    det_d = D_GOT1;
                end
            end
            default: det_d = D_START;
        endcase
        mask_d = mask_q;
        if (hit_d) mask_d[bit_idx_q] = 1'b1;
        count_d = count_q + CW'(hit_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            det_q       <= D_START;
            word_q      <= '0;
            bit_idx_q   <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            count_q     <= '0;
            mask_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
            rsp_mask_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        word_q    <= word_d;
                        id_q      <= grant_id_d;
                        bit_idx_q <= BW'(WIDTH - 1);
                        det_q     <= D_START;
                        count_q   <= '0;
                        mask_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    det_q   <= det_d;
                    mask_q  <= mask_d;
                    count_q <= count_d;
                    // Result registers load from the final-bit next values so
                    // they stay untouched while the next word is shifting.
                    if (bit_idx_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_count_q <= count_d;
                        rsp_mask_q  <= mask_d;
                        state_q     <= S_RESP;
                    end else begin
                        bit_idx_q <= bit_idx_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = grant_d;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_count = rsp_count_q;
    assign bus.rsp_mask  = rsp_mask_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_detect_sched.sv
module tb_serial_detect_sched;
    logic clk;
    logic reset;
    int   cyc;
    int   pass_cnt;
    int   total_cnt;

    serial_detect_sched_if #(.NREQ(4), .WIDTH(8)) bus ();

    serial_detect_sched #(.NREQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cnt;
        logic [7:0] mask;
    } vec_t;

    typedef struct {
        int         id;
        int         cnt;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard consumer: every accepted result is compared with the oldest
    // expectation queued by the driver.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), mon_e.id);
                chk("rsp_count", 32'(bus.rsp_count), mon_e.cnt);
                chk("rsp_mask", 32'(bus.rsp_mask), 32'(mon_e.mask));
            end
        end
    end

    task automatic push_exp(input int id, input int cnt, input logic [7:0] mask);
        exp_t e;
        e.id = id; e.cnt = cnt; e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int id, input string name);
        int n = 0;
        #1;
        while (!bus.req_ready[id] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.req_ready), 32'(1) << id);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    // One word from one requester, rsp_ready assumed high.
    task automatic send(input vec_t v);
        int t_acc;
        int n;
        push_exp(v.id, v.cnt, v.mask);
        bus.req_data[v.id*8 +: 8] = v.data;
        bus.req_valid[v.id] = 1'b1;
        wait_ready(v.id, "grant");
        t_acc = cyc;
        @(posedge clk);
        #1 bus.req_valid[v.id] = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", cyc - t_acc, 9);
    endtask

    vec_t vecs[8];
    int   order[5];

    initial begin
        int last;
        int t;
        int n;
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{0, 8'hC6, 3, 8'h52};
        vecs[1] = '{2, 8'hFF, 4, 8'h55};
        vecs[2] = '{2, 8'h00, 4, 8'h55};
        vecs[3] = '{2, 8'hAA, 0, 8'h00};
        vecs[4] = '{2, 8'hE0, 3, 8'h4A};
        vecs[5] = '{1, 8'h33, 4, 8'h55};
        vecs[6] = '{3, 8'h96, 2, 8'h22};
        vecs[7] = '{1, 8'h7F, 3, 8'h2A};
        order   = '{0, 1, 2, 3, 0};

        // Reset state, with requests present to show no grant under reset.
        reset         = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_count", 32'(bus.rsp_count), 0);
        chk("rst_rsp_mask", 32'(bus.rsp_mask), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        bus.req_valid = '0;
        reset = 1'b0;
        @(negedge clk);

        // Table of single words, issued back-to-back.
        for (int i = 0; i < 8; i++) send(vecs[i]);
        drain();

        // Round-robin with all requesters pending.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.req_data = {8'h7F, 8'h96, 8'h33, 8'hC6};
        push_exp(0, 3, 8'h52);
        push_exp(1, 4, 8'h55);
        push_exp(2, 2, 8'h22);
        push_exp(3, 3, 8'h2A);
        push_exp(0, 3, 8'h52);
        bus.req_valid = 4'hF;
        #1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (bus.req_ready == '0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("rr_onehot", 32'($onehot(bus.req_ready)), 1);
            chk("rr_order", 32'(bus.req_ready), 32'(1) << order[g]);
            if (g > 0) chk("rr_gap", cyc - last, 10);
            last = cyc;
            if (g == 4) begin
                @(posedge clk);
                #1 bus.req_valid = '0;
            end else begin
                @(negedge clk);
            end
        end
        drain();

        // Consumer stall in RESP with another request waiting.
        bus.rsp_ready = 1'b0;
        push_exp(2, 3, 8'h52);
        bus.req_data[2*8 +: 8] = 8'hC6;
        bus.req_valid[2] = 1'b1;
        wait_ready(2, "stall_grant");
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b0;
        bus.req_data[0 +: 8] = 8'h00;
        bus.req_valid[0] = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", 32'(bus.rsp_valid), 1);
            chk("stall_id", 32'(bus.rsp_id), 2);
            chk("stall_count", 32'(bus.rsp_count), 3);
            chk("stall_mask", 32'(bus.rsp_mask), 32'h52);
            chk("stall_no_grant", 32'(bus.req_ready), 0);
            chk("stall_busy", 32'(bus.busy), 1);
            @(negedge clk);
        end
        bus.req_valid[0] = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("post_hs_valid", 32'(bus.rsp_valid), 0);
        chk("post_hs_busy", 32'(bus.busy), 0);

        // Reset in the middle of a shift; rr_ptr would otherwise favour 3.
        bus.req_data[3*8 +: 8] = 8'h7F;
        bus.req_valid[3] = 1'b1;
        wait_ready(3, "mid_grant");
        t = cyc;
        @(posedge clk);
        #1 bus.req_valid[3] = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_cycle", cyc - t, 5);
        chk("mid_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
        reset = 1'b0;
        bus.req_data[1*8 +: 8] = 8'h33;
        push_exp(1, 4, 8'h55);
        bus.req_valid = 4'b1010;
        #1 chk("post_rst_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk);
        #1 bus.req_valid = '0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
